// File: rtl/hazard_fwd_unit_pkg.sv
// Shared hazard/forwarding definitions for the decode stage.
// Operand-source encodings are also used by the EX operand muxes.
package hazard_fwd_unit_pkg;

  localparam int RAW_DEF = 5;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  function automatic logic [1:0] mem_sel(input logic load);
    return load ? FWD_MEMLD : FWD_MEMALU;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_shadow_entry.sv
// One shadow pipeline entry {rd, wreg, load}.
// Synchronous clear, advance enable and bubble insert.
module hazard_shadow_entry #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         en,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard controller: load-use stall, operand
// forwarding selects, branch flush and a saturating stall counter.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int RAW  = RAW_DEF,
  parameter int CNTW = 16
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic            We,
  input  logic [RAW-1:0]  Rs,
  input  logic [RAW-1:0]  Rt,
  input  logic            UseRs,
  input  logic            UseRt,
  input  logic            Wreg,
  input  logic            Reg2reg,
  input  logic [RAW-1:0]  Rd,
  input  logic            BranchTaken,
  output logic            Stall,
  output logic [1:0]      FwdA,
  output logic [1:0]      FwdB,
  output logic            Flush,
  output logic [CNTW-1:0] StallCnt
);

  localparam int EW = RAW + 2;

  logic [EW-1:0]  e_d;
  logic [EW-1:0]  e_q;
  logic [EW-1:0]  m_q;
  logic [RAW-1:0] e_rd;
  logic [RAW-1:0] m_rd;
  logic           e_wreg;
  logic           e_load;
  logic           m_wreg;
  logic           m_load;
  logic           e_bubble;

  assign {e_rd, e_wreg, e_load} = e_q;
  assign {m_rd, m_wreg, m_load} = m_q;
  assign e_d      = {Rd, Wreg, ~Reg2reg};
  assign e_bubble = Stall | BranchTaken;

  hazard_shadow_entry #(.W(EW)) u_e (
    .clk    (Clk),
    .clrn   (Clrn),
    .en     (We),
    .bubble (e_bubble),
    .d      (e_d),
    .q      (e_q)
  );

  hazard_shadow_entry #(.W(EW)) u_m (
    .clk    (Clk),
    .clrn   (Clrn),
    .en     (We),
    .bubble (1'b0),
    .d      (e_q),
    .q      (m_q)
  );

  logic e_hit_a;
  logic e_hit_b;
  logic m_hit_a;
  logic m_hit_b;

  assign e_hit_a = UseRs && e_wreg
                && (e_rd == Rs) && (Rs != '0);
  assign e_hit_b = UseRt && e_wreg
                && (e_rd == Rt) && (Rt != '0);
  assign m_hit_a = UseRs && m_wreg
                && (m_rd == Rs) && (Rs != '0);
  assign m_hit_b = UseRt && m_wreg
                && (m_rd == Rt) && (Rt != '0);

  // A load in E cannot forward yet; branch squashes the stall.
  logic load_use;

  assign load_use = (e_hit_a | e_hit_b) & e_load;
  assign Stall    = load_use & ~BranchTaken;
  assign Flush    = BranchTaken;

  // Younger E entry wins; terms made exclusive for the decoder.
  logic e_fwd_a;
  logic e_fwd_b;
  logic m_fwd_a;
  logic m_fwd_b;

  assign e_fwd_a = e_hit_a & ~e_load;
  assign e_fwd_b = e_hit_b & ~e_load;
  assign m_fwd_a = m_hit_a & ~e_fwd_a;
  assign m_fwd_b = m_hit_b & ~e_fwd_b;

  always_comb begin
    FwdA = FWD_RF;
    unique case (1'b1)
      e_fwd_a: FwdA = FWD_EXALU;
      m_fwd_a: FwdA = mem_sel(m_load);
      default: FwdA = FWD_RF;
    endcase
  end

  always_comb begin
    FwdB = FWD_RF;
    unique case (1'b1)
      e_fwd_b: FwdB = FWD_EXALU;
      m_fwd_b: FwdB = mem_sel(m_load);
      default: FwdB = FWD_RF;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      StallCnt <= '0;
    end else if (We && Stall && (StallCnt != '1)) begin
      StallCnt <= StallCnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit (CNTW=4 build).
// Reference model tracks the two older instructions as records.
module tb_hazard_fwd_unit;

  localparam int RAW  = 5;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  typedef struct {
    logic           clrn;
    logic           we;
    logic [RAW-1:0] rs;
    logic           urs;
    logic [RAW-1:0] rt;
    logic           urt;
    logic [RAW-1:0] rd;
    logic           wreg;
    logic           r2r;
    logic           br;
  } stim_t;

  typedef struct {
    logic [RAW-1:0] rd;
    logic           wreg;
    logic           load;
  } rec_t;

  typedef struct {
    logic            stall;
    logic            flush;
    logic [1:0]      fa;
    logic [1:0]      fb;
    logic [CNTW-1:0] cnt;
  } exp_t;

  logic            Clk = 1'b0;
  logic            Clrn;
  logic            We;
  logic [RAW-1:0]  Rs;
  logic [RAW-1:0]  Rt;
  logic            UseRs;
  logic            UseRt;
  logic            Wreg;
  logic            Reg2reg;
  logic [RAW-1:0]  Rd;
  logic            BranchTaken;
  logic            Stall;
  logic [1:0]      FwdA;
  logic [1:0]      FwdB;
  logic            Flush;
  logic [CNTW-1:0] StallCnt;

  hazard_fwd_unit #(.RAW(RAW), .CNTW(CNTW)) dut (
    .Clk         (Clk),
    .Clrn        (Clrn),
    .We          (We),
    .Rs          (Rs),
    .Rt          (Rt),
    .UseRs       (UseRs),
    .UseRt       (UseRt),
    .Wreg        (Wreg),
    .Reg2reg     (Reg2reg),
    .Rd          (Rd),
    .BranchTaken (BranchTaken),
    .Stall       (Stall),
    .FwdA        (FwdA),
    .FwdB        (FwdB),
    .Flush       (Flush),
    .StallCnt    (StallCnt)
  );

  always #5 Clk = ~Clk;

  // older[0] = instruction now in EX, older[1] = instruction in MEM
  rec_t older[2];
  int   cnt_m  = 0;
  bit   known  = 0;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Youngest older writer of r supplies the operand; a load still in
  // EX cannot, so it is flagged as load-use and MEM is consulted.
  function automatic logic [1:0] src_of(input logic [RAW-1:0] r,
                                        input logic u,
                                        output logic ldu);
    logic [1:0] s;
    bit done;
    s = 2'b00;
    done = 0;
    ldu = 1'b0;
    if (u && r != 0) begin
      for (int k = 0; k < 2; k++) begin
        if (!done && older[k].wreg && older[k].rd == r) begin
          if (k == 0 && older[k].load) begin
            ldu = 1'b1;
          end else begin
            s = (k == 0) ? 2'b01 : (older[k].load ? 2'b11 : 2'b10);
            done = 1;
          end
        end
      end
    end
    return s;
  endfunction

  task automatic chk(input string n, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    logic la;
    logic lb;
    logic st;
    Clrn = s.clrn;
    We = s.we;
    Rs = s.rs;
    UseRs = s.urs;
    Rt = s.rt;
    UseRt = s.urt;
    Rd = s.rd;
    Wreg = s.wreg;
    Reg2reg = s.r2r;
    BranchTaken = s.br;
    e.fa = src_of(s.rs, s.urs, la);
    e.fb = src_of(s.rt, s.urt, lb);
    st = (la | lb) & ~s.br;
    e.stall = st;
    e.flush = s.br;
    e.cnt = CNTW'(cnt_m);
    if (known) sb.push_back(e);
    @(posedge Clk);
    if (!s.clrn) begin
      older[0] = '{rd: '0, wreg: 1'b0, load: 1'b0};
      older[1] = '{rd: '0, wreg: 1'b0, load: 1'b0};
      cnt_m = 0;
      known = 1;
    end else if (s.we) begin
      if (st && cnt_m < CMAX) cnt_m++;
      older[1] = older[0];
      if (st || s.br)
        older[0] = '{rd: '0, wreg: 1'b0, load: 1'b0};
      else
        older[0] = '{rd: s.rd, wreg: s.wreg, load: ~s.r2r};
    end
    #1;
  endtask

  function automatic stim_t mk(input logic we,
                               input int rs, input logic urs,
                               input int rt, input logic urt,
                               input int rd, input logic wreg,
                               input logic r2r, input logic br);
    stim_t s;
    s.clrn = 1'b1;
    s.we = we;
    s.rs = RAW'(rs);
    s.urs = urs;
    s.rt = RAW'(rt);
    s.urt = urt;
    s.rd = RAW'(rd);
    s.wreg = wreg;
    s.r2r = r2r;
    s.br = br;
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", 16'(Stall), 16'(e.stall));
        chk("flush", 16'(Flush), 16'(e.flush));
        chk("stall_cnt", 16'(StallCnt), 16'(e.cnt));
        if (!e.stall) begin
          chk("fwd_a", 16'(FwdA), 16'(e.fa));
          chk("fwd_b", 16'(FwdB), 16'(e.fb));
        end
      end
    end
  end

  initial begin : stim
    stim_t r;
    older[0] = '{rd: '0, wreg: 1'b0, load: 1'b0};
    older[1] = '{rd: '0, wreg: 1'b0, load: 1'b0};
    r = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
    r.clrn = 1'b0;
    step(r);
    step(r);
    // reset then a plain reader
    step(mk(1, 3, 1, 0, 0, 0, 0, 1, 0));
    // ALU RAW: EX forward, then MEM forward
    step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0));
    step(mk(1, 5, 1, 5, 1, 9, 1, 1, 0));
    step(mk(1, 5, 1, 5, 1, 0, 0, 1, 0));
    // load-use: one stall then MEM load forward
    step(mk(1, 0, 0, 0, 0, 7, 1, 0, 0));
    step(mk(1, 0, 0, 7, 1, 2, 1, 1, 0));
    step(mk(1, 0, 0, 7, 1, 2, 1, 1, 0));
    // register zero
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(1, 0, 1, 0, 1, 3, 1, 1, 0));
    // branch beats load-use
    step(mk(1, 0, 0, 0, 0, 4, 1, 0, 0));
    step(mk(1, 4, 1, 0, 0, 6, 1, 1, 1));
    step(mk(1, 6, 1, 4, 1, 0, 0, 1, 0));
    step(mk(1, 0, 0, 0, 0, 11, 1, 1, 0));
    step(mk(1, 0, 0, 12, 1, 0, 0, 1, 0));
    step(mk(1, 11, 1, 0, 0, 0, 0, 1, 1));
    step(mk(1, 11, 1, 0, 0, 0, 0, 1, 0));
    // hold during a pending load-use
    step(mk(1, 0, 0, 0, 0, 8, 1, 0, 0));
    repeat (3) step(mk(0, 8, 1, 0, 0, 1, 1, 1, 0));
    step(mk(1, 8, 1, 0, 0, 1, 1, 1, 0));
    step(mk(1, 8, 1, 0, 0, 1, 1, 1, 0));
    // drive the counter into saturation
    repeat (20) begin
      step(mk(1, 0, 0, 0, 0, 9, 1, 0, 0));
      step(mk(1, 9, 1, 9, 1, 10, 1, 1, 0));
      step(mk(1, 9, 1, 9, 1, 10, 1, 1, 0));
    end
    r = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
    r.clrn = 1'b0;
    step(r);
    repeat (600) begin
      r.clrn = ($urandom_range(0, 99) != 0);
      r.we = ($urandom_range(0, 7) != 0);
      r.rs = RAW'($urandom_range(0, 7));
      r.rt = RAW'($urandom_range(0, 7));
      r.rd = RAW'($urandom_range(0, 7));
      r.urs = 1'($urandom_range(0, 1));
      r.urt = 1'($urandom_range(0, 1));
      r.wreg = ($urandom_range(0, 3) != 0);
      r.r2r = 1'($urandom_range(0, 1));
      r.br = ($urandom_range(0, 9) == 0);
      step(r);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Decode-stage hazard controller for the 5-stage pipeline, sitting directly upstream of the ID/EX pipeline register.
- Produces the `stall`, `FwdA` and `FwdB` values that ID/EX latches, plus the IF/ID flush.
- Keeps its own shadow copy of the EX and MEM destination information, so it needs no feedback from downstream registers other than the branch-taken flag.
- Counts stall cycles for performance observation.

Parameters:
- RAW, 5, register-address width
- CNTW, 16, stall-counter width (saturating)

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Clrn  in  1  synchronous active-low reset
- We  in  1  pipeline advance enable (same signal that drives ID/EX We)
- Rs  in  RAW  ID source register A
- Rt  in  RAW  ID source register B
- UseRs  in  1  ID instruction reads Rs
- UseRt  in  1  ID instruction reads Rt
- Wreg  in  1  ID instruction writes the register file
- Reg2reg  in  1  ID result source: 1 = ALU, 0 = memory (load)
- Rd  in  RAW  ID destination register
- BranchTaken  in  1  EX-stage branch resolved taken this cycle
- Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- FwdA  out  2  operand A source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- FwdB  out  2  operand B source, same encoding as FwdA
- Flush  out  1  clear IF/ID (squash wrong-path fetch)
- StallCnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Shadow state, one entry per stage:
  - E entry: rd, wreg, load.
  - M entry: rd, wreg, load.
- Reset: on a rising edge with Clrn=0, clear both entries (wreg=0, load=0, rd=0) and set StallCnt=0. Reset takes priority over We, stall and branch.
- Outputs Stall, FwdA, FwdB and Flush are combinational from current inputs and shadow state, valid in the same cycle.
- Consequence of reset: in the cycle after reset, with BranchTaken=0, Stall=0, FwdA=FwdB=00 and Flush=0.
- Register 0 never matches. A source or destination equal to 0 yields no forward and no stall.
- Match E(x): UseX && E.wreg && E.rd==X && X!=0.
- Match M(x): UseX && M.wreg && M.rd==X && X!=0.
- Forward select for each operand, in priority order:
  - E match with E.load=0 -> 01.
  - Else M match -> 10 if M.load=0, 11 if M.load=1.
  - Else 00.
- Load-use stall: Stall=1 when (match E(Rs) or match E(Rt)) and E.load=1.
  - While Stall=1, FwdA and FwdB are don't-care; the bubble clears them.
- Flush = BranchTaken.
- BranchTaken=1 forces Stall=0, because the ID instruction is on the wrong path. Branch wins over a simultaneous stall.
- Shadow update on a rising edge with We=1:
  - M <= E.
  - E <= bubble (all zero) if Stall or BranchTaken.
  - Otherwise E <= {Rd, Wreg, ~Reg2reg}.
- We=0: shadow entries hold, StallCnt holds, and combinational outputs still track the inputs.
- StallCnt increments on each We=1 edge where Stall=1, and saturates at all-ones with no wrap.
- Load followed by a dependent instruction:
  - Cycle 1: stall for exactly one cycle.
  - Cycle 2: the load is in M and E is a bubble, so select 11 and Stall=0.
- Load two instructions ahead of the dependent instruction: no stall, select 11.
- Same register written in both E and M: the E (younger) entry wins.

Decomposition:
- Shared package: the FwdA/FwdB encodings (FWD_RF=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMLD=2'b11) and the RAW default. The ID/EX consumer and the EX operand muxes use the same constants.
- One sub-module, hazard_shadow_entry: a RAW+2-bit register with synchronous clear, enable and bubble-insert, instantiated for E and M. Match, priority and stall logic stay in the top.

Test Plan:
- Reset:
  - Stimulus: Clrn=0 for 2 cycles, then Rs=3, UseRs=1, We=1.
  - Required: Stall=0, FwdA=00, Flush=0, StallCnt=0.
- ALU RAW:
  - Stimulus: issue Rd=5, Wreg=1, Reg2reg=1; next cycle Rs=5, Rt=5, both used.
  - Required: FwdA=FwdB=01. One cycle later, with an unrelated instruction between: 10.
- Load-use:
  - Stimulus: issue a load to Rd=7 (Reg2reg=0); next cycle Rt=7, UseRt=1.
  - Required: Stall=1 for one cycle, StallCnt=1. In the following cycle Stall=0 and FwdB=11.
- Register zero:
  - Stimulus: issue a load to Rd=0; next cycle Rs=0, UseRs=1.
  - Required: Stall=0, FwdA=00.
- Branch vs. stall:
  - Stimulus: a load-use condition and BranchTaken=1 in the same cycle.
  - Required: Flush=1, Stall=0, StallCnt unchanged, E shadow becomes a bubble. Next cycle, Rs matching the squashed Rd gives FwdA=10 only if the older M entry matches, else 00.
- Hold and saturation:
  - Stimulus: We=0 during a pending load-use.
  - Required: StallCnt holds and shadow is unchanged.
  - Stimulus: preload StallCnt to all-ones via repeated stalls (CNTW=4 build).
  - Required: it remains 4'hF.
